weight_load_seq: RTL and testbench

Weight-load sequencer for the CNN accelerator. It takes a start command with a filter count and an elements-per-filter count. It then steers the 2-element-per-beat AXI weight stream into the per-filter weight buffers, one filter at a time, through a one-hot `weight_en_o`. It sits between the AXI input port and the weight buffer bank and replaces inline weight-loading sequencing in the top-level CNN control. It reports `done_o` when all filters are loaded.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/onehot_dec.sv | 19 +
 rtl/weight_load_seq.sv | 172 +++++++++++++++++
 tb/tb_weight_load_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator types and constants.
// Used by the weight-load sequencer and the buffer select decoders.
package cnn_pkg;

  localparam int unsigned CNN_MAX_FILTERS = 32;
  localparam int unsigned CNN_AXI_ELEMS   = 2;

  typedef enum logic [1:0] {
    WLS_IDLE = 2'd0,
    WLS_LOAD = 2'd1,
    WLS_DONE = 2'd2
  } wls_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder, gated by an enable.
// Shared by the weight and image buffer selects.
module onehot_dec #(
  parameter int unsigned N  = 32,
  parameter int unsigned IW = 6
) (
  input  logic          en_i,
  input  logic [IW-1:0] idx_i,
  output logic [N-1:0]  oh_o
);

  always_comb begin
    oh_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      oh_o[i] = en_i && (32'(idx_i) == i);
    end
  end

endmodule

// File: rtl/weight_load_seq.sv
// Weight-load sequencer: steers the AXI weight stream into per-filter buffers.
// Optional write backpressure via `WLS_BACKPRESSURE_EN (adds wr_ready_i).
module weight_load_seq
  import cnn_pkg::*;
#(
  parameter int unsigned MAX_FILTERS = CNN_MAX_FILTERS,
  parameter int unsigned ELEM_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [5:0]                        n_filters_i,
  input  logic [5:0]                        n_elem_i,
  input  logic                              abort_i,
  input  logic                              s_valid_i,
  input  logic [CNN_AXI_ELEMS*ELEM_W-1:0]   s_data_i,
  output logic                              s_ready_o,
`ifdef WLS_BACKPRESSURE_EN
  input  logic                              wr_ready_i,
`endif
  output logic                              wr_valid_o,
  output logic [CNN_AXI_ELEMS*ELEM_W-1:0]   wr_data_o,
  output logic [1:0]                        wr_mask_o,
  output logic [MAX_FILTERS-1:0]            weight_en_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int unsigned DW = CNN_AXI_ELEMS * ELEM_W;

  wls_state_t state_q, state_d;

  logic [5:0]    nf_q, nf_d;
  logic [5:0]    ne_q, ne_d;
  logic [5:0]    filt_q, filt_d;
  logic [5:0]    elem_q, elem_d;
  logic [5:0]    idx_q, idx_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    mask_q, mask_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic       wr_free;
  logic       in_load;
  logic       accept;
  logic       cfg_bad;
  logic       tail;
  logic [5:0] elem_inc;
  logic [5:0] filt_inc;

`ifdef WLS_BACKPRESSURE_EN
  assign wr_free = !vld_q || wr_ready_i;
`else
  assign wr_free = 1'b1;
`endif

  assign in_load  = (state_q == WLS_LOAD);
  assign s_ready_o = in_load && wr_free;
  assign accept   = s_valid_i && s_ready_o && !abort_i;

  assign cfg_bad = (n_filters_i == 6'd0)
                || (32'(n_filters_i) > MAX_FILTERS)
                || (n_elem_i == 6'd0);

  // Odd tail: only lane 0 belongs to this filter.
  assign tail     = (ne_q - elem_q) == 6'd1;
  assign elem_inc = elem_q + (tail ? 6'd1 : 6'd2);
  assign filt_inc = filt_q + 6'd1;

  always_comb begin
    state_d = state_q;
    nf_d    = nf_q;
    ne_d    = ne_q;
    filt_d  = filt_q;
    elem_d  = elem_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;
    vld_d   = vld_q && !wr_free;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (abort_i) begin
      state_d = WLS_IDLE;
      filt_d  = '0;
      elem_d  = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        WLS_IDLE: begin
          if (start_i && cfg_bad) begin
            err_d = 1'b1;
          end else if (start_i) begin
            nf_d    = n_filters_i;
            ne_d    = n_elem_i;
            filt_d  = '0;
            elem_d  = '0;
            state_d = WLS_LOAD;
          end
        end
        WLS_LOAD: begin
          if (accept) begin
            vld_d  = 1'b1;
            data_d = s_data_i;
            idx_d  = filt_q;
            mask_d = tail ? 2'b01 : 2'b11;
            if (elem_inc == ne_q) begin
              elem_d = '0;
              filt_d = filt_inc;
              if (filt_inc == nf_q) state_d = WLS_DONE;
            end else begin
              elem_d = elem_inc;
            end
          end
        end
        WLS_DONE: begin
          if (wr_free) begin
            done_d  = 1'b1;
            state_d = WLS_IDLE;
          end
        end
        default: state_d = WLS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WLS_IDLE;
      nf_q    <= '0;
      ne_q    <= '0;
      filt_q  <= '0;
      elem_q  <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nf_q    <= nf_d;
      ne_q    <= ne_d;
      filt_q  <= filt_d;
      elem_q  <= elem_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  onehot_dec #(
    .N  (MAX_FILTERS),
    .IW (6)
  ) u_sel (
    .en_i  (vld_q),
    .idx_i (idx_q),
    .oh_o  (weight_en_o)
  );

  assign wr_valid_o = vld_q;
  assign wr_data_o  = data_q;
  assign wr_mask_o  = mask_q;
  assign busy_o     = in_load;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_weight_load_seq.sv
// Directed self-checking bench for weight_load_seq.
// Build with WLS_BACKPRESSURE_EN defined to cover the write stall case.
module tb_weight_load_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic [5:0]  n_filters_i = '0;
  logic [5:0]  n_elem_i = '0;
  logic [31:0] s_data_i = '0;
  logic        s_ready_o;
  logic        wr_valid_o;
  logic [31:0] wr_data_o;
  logic [1:0]  wr_mask_o;
  logic [31:0] weight_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
`ifdef WLS_BACKPRESSURE_EN
  logic        wr_ready_i = 1'b1;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc = 0;
  int en_glitch = 0;
  int w0;
  int d0;

  logic [1:0]  wm[$];
  logic [31:0] we[$];
  logic [31:0] wd[$];
  int          wc[$];

  logic [5:0] bad_nf[3] = '{6'd0, 6'd33, 6'd1};
  logic [5:0] bad_ne[3] = '{6'd5, 6'd5, 6'd0};

  weight_load_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .n_filters_i (n_filters_i),
    .n_elem_i    (n_elem_i),
    .abort_i     (abort_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
`ifdef WLS_BACKPRESSURE_EN
    .wr_ready_i  (wr_ready_i),
`endif
    .wr_valid_o  (wr_valid_o),
    .wr_data_o   (wr_data_o),
    .wr_mask_o   (wr_mask_o),
    .weight_en_o (weight_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic wr_take;
`ifdef WLS_BACKPRESSURE_EN
  assign wr_take = wr_valid_o && wr_ready_i;
`else
  assign wr_take = wr_valid_o;
`endif

  always @(negedge clk) begin
    if (wr_take) begin
      wm.push_back(wr_mask_o);
      we.push_back(weight_en_o);
      wd.push_back(wr_data_o);
      wc.push_back(cyc);
    end
    if (!wr_valid_o && weight_en_o != 0) en_glitch <= en_glitch + 1;
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (s_valid_i && s_ready_o && !abort_i) last_acc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int k);
    return {16'(2 * k + 1), 16'(2 * k)};
  endfunction

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [5:0] nf, input logic [5:0] ne);
    n_filters_i = nf;
    n_elem_i = ne;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_beats(input int k0, input int n, input bit tog);
    int k;
    logic acc;
    k = k0;
    s_valid_i = 1'b1;
    s_data_i = beat(k);
    for (int c = 0; c < 400 && k < n; c++) begin
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      @(posedge clk);
      #1;
      if (acc) k++;
      s_valid_i = tog ? !s_valid_i : 1'b1;
      s_data_i = beat(k);
    end
    s_valid_i = 1'b0;
    chk("beats_fed", k, n);
  endtask

  task automatic mark();
    w0 = wm.size();
    d0 = done_cnt;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ctl", {s_ready_o, wr_valid_o, wr_mask_o,
                    busy_o, done_o, err_o}, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_en", weight_en_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 3 filters x 9 elems, continuous stream
    mark();
    start_cmd(6'd3, 6'd9);
    run_beats(0, 15, 1'b0);
    settle(6);
    chk("t1_nwr", wm.size() - w0, 15);
    for (int i = 0; i < 15; i++) begin
      chk("t1_mask", wm[w0+i], (i % 5 == 4) ? 2'b01 : 2'b11);
      chk("t1_en", we[w0+i], 32'h1 << (i / 5));
      chk("t1_data", wd[w0+i], beat(i));
    end
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_done_lat", done_cyc - last_acc, 2);

    // illegal configurations
    for (int j = 0; j < 3; j++) begin
      n_filters_i = bad_nf[j];
      n_elem_i = bad_ne[j];
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      @(negedge clk);
      chk("t2_err", err_o, 1);
      chk("t2_busy", busy_o, 0);
      @(negedge clk);
      chk("t2_err_once", err_o, 0);
      chk("t2_busy2", busy_o, 0);
      @(posedge clk);
      #1;
    end

    // 1 filter x 4 elems, valid every other cycle
    mark();
    start_cmd(6'd1, 6'd4);
    run_beats(0, 2, 1'b1);
    settle(6);
    chk("t3_nwr", wm.size() - w0, 2);
    chk("t3_mask0", wm[w0], 2'b11);
    chk("t3_mask1", wm[w0+1], 2'b11);
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_done_lat", done_cyc - wc[w0+1], 1);

    // abort in filter 1 of 4, beat offered alongside abort
    mark();
    start_cmd(6'd4, 6'd4);
    run_beats(0, 3, 1'b0);
    abort_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = beat(3);
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_busy", busy_o, 0);
    chk("t4_en", weight_en_o, 0);
    chk("t4_vld", wr_valid_o, 0);
    settle(5);
    chk("t4_nwr", wm.size() - w0, 3);
    chk("t4_nodone", done_cnt - d0, 0);
    mark();
    start_cmd(6'd2, 6'd2);
    run_beats(0, 2, 1'b0);
    settle(6);
    chk("t4b_nwr", wm.size() - w0, 2);
    chk("t4b_en0", we[w0], 32'h1);
    chk("t4b_en1", we[w0+1], 32'h2);
    chk("t4b_done", done_cnt - d0, 1);

    // 32 filters x 1 elem: full one-hot range, tail-only beats
    mark();
    start_cmd(6'd32, 6'd1);
    run_beats(0, 32, 1'b0);
    settle(6);
    chk("t5_nwr", wm.size() - w0, 32);
    for (int i = 0; i < 32; i++) begin
      chk("t5_en", we[w0+i], 32'h1 << i);
      chk("t5_mask", wm[w0+i], 2'b01);
    end
    chk("t5_done", done_cnt - d0, 1);

    // asynchronous reset mid-load
    start_cmd(6'd2, 6'd6);
    run_beats(0, 2, 1'b0);
    chk("t6_pre", {busy_o, wr_valid_o}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_ctl", {s_ready_o, wr_valid_o, wr_mask_o,
                   busy_o, done_o, err_o}, 0);
    chk("t6_data", wr_data_o, 0);
    chk("t6_en", weight_en_o, 0);
    s_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rdy", s_ready_o, 0);
    chk("t6_busy", busy_o, 0);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    mark();
    start_cmd(6'd1, 6'd1);
    run_beats(0, 1, 1'b0);
    settle(6);
    chk("t6_nwr", wm.size() - w0, 1);
    chk("t6_en1", we[w0], 32'h1);
    chk("t6_done", done_cnt - d0, 1);

`ifdef WLS_BACKPRESSURE_EN
    // write side stalls for 3 cycles inside filter 0
    mark();
    start_cmd(6'd2, 6'd4);
    run_beats(0, 1, 1'b0);
    wr_ready_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = beat(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_vld", wr_valid_o, 1);
      chk("bp_data", wr_data_o, beat(0));
      chk("bp_en", weight_en_o, 32'h1);
      chk("bp_rdy", s_ready_o, 0);
    end
    @(posedge clk);
    #1;
    wr_ready_i = 1'b1;
    run_beats(1, 4, 1'b0);
    settle(6);
    chk("bp_nwr", wm.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_wdata", wd[w0+i], beat(i));
      chk("bp_wen", we[w0+i], 32'h1 << (i / 2));
    end
    chk("bp_done", done_cnt - d0, 1);
`endif

    chk("en_idle_zero", en_glitch, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
